// File: rtl/i2c_slave_mem_if.sv
// I2C slave pins plus the byte-wide memory port of i2c_slave_mem.
// slave = the responder side, master = bus master / memory side.
interface i2c_slave_mem_if #(
    parameter int MEM_AW = 6
);
    logic              scl_i;
    logic              sda_i;
    logic              sda_oe;
    logic              mem_ce;
    logic              mem_rden;
    logic              mem_wren;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  scl_i, sda_i, mem_rdata,
        output sda_oe, mem_ce, mem_rden, mem_wren, mem_addr, mem_wdata
    );

    modport master (
        output scl_i, sda_i, mem_rdata,
        input  sda_oe, mem_ce, mem_rden, mem_wren, mem_addr, mem_wdata
    );
endinterface

// File: rtl/i2c_slave_mem.sv
// I2C memory slave on an 8x oversampling clock; open-drain SDA via sda_oe.
// Define I2C_SLAVE_ADDR_AUTOINC_EN to step mem_addr after every data byte.
module i2c_slave_mem #(
    parameter logic [6:0] DEV_ADDR = 7'h01,
    parameter int         MEM_AW   = 6
) (
    input  logic                  clk8x,
    input  logic                  reset,
    i2c_slave_mem_if.slave        bus,
    output logic                  busy,
    output logic [3:0]            state
);
    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_MEM_ADDR, S_MEM_ACK, S_WR_DATA,
        S_WR_ACK, S_RD_LOAD, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t            cur, nxt;
    logic [1:0]        scl_sync, sda_sync;
    logic              scl_hist, sda_hist;
    logic [3:0]        bit_cnt, cnt_n;
    logic [7:0]        shreg, sh_n;
    logic              rw, rw_n;
    logic [MEM_AW-1:0] addr, addr_n, addr_step;
    logic [7:0]        wdata, wdata_n;
    logic              oe, oe_n;
    logic              busy_r, busy_n;
    logic              rden, rden_n, wren, wren_n;

    // Idle bus is high, so the synchronizers reset to 1.
    always_ff @(posedge clk8x) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    logic scl, sda, scl_rise, scl_fall, sda_fall, sda_rise;
    logic start_c, stop_c, last_bit;
    logic [7:0] byte_in;

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_hist;
    assign scl_fall = ~scl & scl_hist;
    assign sda_fall = ~sda & sda_hist;
    assign sda_rise = sda & ~sda_hist;
    assign start_c  = sda_fall & scl;
    assign stop_c   = sda_rise & scl;
    assign byte_in  = {shreg[6:0], sda};
    assign last_bit = (bit_cnt == 4'd7);

`ifdef I2C_SLAVE_ADDR_AUTOINC_EN
    assign addr_step = addr + MEM_AW'(1);
`else
    assign addr_step = addr;
`endif

    always_ff @(posedge clk8x) begin
        if (reset) begin
            cur     <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            rw      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            oe      <= 1'b0;
            busy_r  <= 1'b0;
            rden    <= 1'b0;
            wren    <= 1'b0;
        end else begin
            cur     <= nxt;
            bit_cnt <= cnt_n;
            shreg   <= sh_n;
            rw      <= rw_n;
            addr    <= addr_n;
            wdata   <= wdata_n;
            oe      <= oe_n;
            busy_r  <= busy_n;
            rden    <= rden_n;
            wren    <= wren_n;
        end
    end

    // Ack states: first scl_fall pulls SDA, the closing one releases it.
    always_comb begin
        nxt     = cur;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        rw_n    = rw;
        addr_n  = addr;
        wdata_n = wdata;
        oe_n    = oe;
        busy_n  = busy_r;
        rden_n  = 1'b0;
        wren_n  = 1'b0;
        if (stop_c) begin
            nxt    = S_IDLE;
            oe_n   = 1'b0;
            busy_n = 1'b0;
        end else if (start_c) begin
            nxt   = S_DEV_ADDR;
            cnt_n = '0;
            oe_n  = 1'b0;
        end else begin
            unique case (cur)
                S_IDLE: ;
                S_DEV_ADDR: if (scl_rise) begin
                    sh_n  = byte_in;
                    cnt_n = bit_cnt + 4'd1;
                    if (last_bit) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                            nxt    = S_DEV_ACK;
                            rw_n   = byte_in[0];
                            busy_n = 1'b1;
                        end else begin
                            nxt = S_WAIT_STOP;
                        end
                    end
                end
                S_DEV_ACK: if (scl_fall) begin
                    oe_n = ~oe;
                    if (oe) begin
                        nxt   = S_MEM_ADDR;
                        cnt_n = '0;
                    end
                end
                S_MEM_ADDR: if (scl_rise) begin
                    sh_n  = byte_in;
                    cnt_n = bit_cnt + 4'd1;
                    if (last_bit) begin
                        addr_n = byte_in[MEM_AW-1:0];
                        nxt    = S_MEM_ACK;
                    end
                end
                S_MEM_ACK: if (scl_fall) begin
                    oe_n = ~oe;
                    if (oe) begin
                        cnt_n = '0;
                        if (rw) begin
                            nxt    = S_RD_LOAD;
                            rden_n = 1'b1;
                        end else begin
                            nxt = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: if (scl_rise) begin
                    sh_n  = byte_in;
                    cnt_n = bit_cnt + 4'd1;
                    if (last_bit) begin
                        wdata_n = byte_in;
                        wren_n  = 1'b1;
                        nxt     = S_WR_ACK;
                    end
                end
                S_WR_ACK: if (scl_fall) begin
                    oe_n = ~oe;
                    if (oe) begin
                        addr_n = addr_step;
                        cnt_n  = '0;
                        nxt    = S_WR_DATA;
                    end
                end
                // rden is high on entry; rdata is valid once it has dropped.
                S_RD_LOAD: if (!rden) begin
                    sh_n  = {bus.mem_rdata[6:0], 1'b0};
                    oe_n  = ~bus.mem_rdata[7];
                    cnt_n = 4'd1;
                    nxt   = S_RD_DATA;
                end
                S_RD_DATA: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        oe_n = 1'b0;
                        nxt  = S_RD_ACK;
                    end else begin
                        oe_n  = ~shreg[7];
                        sh_n  = {shreg[6:0], 1'b0};
                        cnt_n = bit_cnt + 4'd1;
                    end
                end
                S_RD_ACK: if (scl_rise && sda) begin
                    nxt = S_WAIT_STOP;
                end else if (scl_fall) begin
                    addr_n = addr_step;
                    rden_n = 1'b1;
                    nxt    = S_RD_LOAD;
                end
                S_WAIT_STOP: oe_n = 1'b0;
                default: nxt = S_IDLE;
            endcase
        end
    end

    assign bus.sda_oe    = oe;
    assign bus.mem_ce    = rden | wren;
    assign bus.mem_rden  = rden;
    assign bus.mem_wren  = wren;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign busy          = busy_r;
    assign state         = cur;
endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-banged I2C master, memory model, scoreboards.
// Expectations follow I2C_SLAVE_ADDR_AUTOINC_EN when it is defined.
module tb_i2c_slave_mem;
    localparam int Q = 4;
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_DEV_ADDR  = 4'd1;
    localparam logic [3:0] ST_RD_DATA   = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP = 4'd10;
`ifdef I2C_SLAVE_ADDR_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk8x = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [3:0] state;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic [7:0] rd_q = 8'h00;
    logic       pre_we = 1'b0;
    logic [5:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    logic [7:0] mem [64];
    int         n_pass = 0;
    int         n_total = 0;

    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic [7:0]  exp_b[$];

    i2c_slave_mem_if #(.MEM_AW(6)) bus ();

    i2c_slave_mem #(.DEV_ADDR(7'h01), .MEM_AW(6)) dut (
        .clk8x(clk8x),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .state(state)
    );

    always #5 clk8x = ~clk8x;

    assign sda_line      = sda_m & ~bus.sda_oe;
    assign bus.scl_i     = scl_m;
    assign bus.sda_i     = sda_line;
    assign bus.mem_rdata = rd_q;

    // Memory model: registered read, data valid the cycle after rden.
    always @(posedge clk8x) begin
        if (bus.mem_rden) rd_q <= mem[bus.mem_addr];
        if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    always @(negedge clk8x) begin
        if (bus.mem_rden || bus.mem_wren)
            obs_q.push_back({bus.mem_ce, bus.mem_rden, bus.mem_wren,
                             bus.mem_addr,
                             bus.mem_wren ? bus.mem_wdata : 8'h00});
    end

    function automatic logic [16:0] wr_ev(logic [5:0] a, logic [7:0] d);
        return {3'b101, a, d};
    endfunction

    function automatic logic [16:0] rd_ev(logic [5:0] a);
        return {3'b110, a, 8'h00};
    endfunction

    task automatic wq();
        repeat (Q) @(negedge clk8x);
    endtask

    task automatic preload(input logic [5:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk8x);
        pre_we   = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b0;
        wq();
    endtask

    task automatic i2c_rstart();
        scl_m = 1'b0; wq();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        scl_m = 1'b0; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            scl_m = 1'b0; wq();
            sda_m = b[i]; wq();
            scl_m = 1'b1; wq();
            wq();
        end
        scl_m = 1'b0; wq();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        ack = sda_line;
        wq();
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            scl_m = 1'b0; wq();
            sda_m = 1'b1; wq();
            scl_m = 1'b1; wq();
            b[i] = sda_line;
            wq();
        end
        scl_m = 1'b0; wq();
        sda_m = ~m_ack; wq();
        scl_m = 1'b1; wq();
        wq();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk8x);
        reset = 1'b0;
        @(negedge clk8x);
        n_total++;
        if (bus.sda_oe !== 1'b0) $display("FAIL rst_sda_oe got %b want 0", bus.sda_oe);
        else n_pass++;
        n_total++;
        if ({bus.mem_ce, bus.mem_rden, bus.mem_wren} !== 3'b000)
            $display("FAIL rst_strobes got %b want 000",
                     {bus.mem_ce, bus.mem_rden, bus.mem_wren});
        else n_pass++;
        n_total++;
        if ({bus.mem_addr, bus.mem_wdata} !== 14'h0)
            $display("FAIL rst_addr_data got %h want 0", {bus.mem_addr, bus.mem_wdata});
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (state !== ST_IDLE) $display("FAIL rst_state got %0d want %0d", state, ST_IDLE);
        else n_pass++;
    endtask

    task automatic test_write();
        logic [7:0]  tx [3] = '{8'h02, 8'h02, 8'h7F};
        logic        ack;
        logic [16:0] e, o;
        int          n;
        exp_q.push_back(wr_ev(6'h02, 8'h7F));
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(tx[i], ack);
            n_total++;
            if (ack !== 1'b0) $display("FAIL wr_ack%0d got %b want 0", i, ack);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b1) $display("FAIL wr_busy got %b want 1", busy);
        else n_pass++;
        i2c_stop();
        wq();
        n_total++;
        if ({busy, state} !== {1'b0, ST_IDLE})
            $display("FAIL wr_end got busy=%b st=%0d want busy=0 st=0", busy, state);
        else n_pass++;
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int k = 0; k < n; k++) begin
            e = '0; o = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL wr_mem%0d got %h want %h", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_read();
        logic        ack;
        logic [7:0]  b, want;
        logic [16:0] e, o;
        int          n;
        preload(6'h01, 8'hA5);
        preload(6'h02, 8'h5C);
        exp_q.push_back(rd_ev(6'h01));
        exp_q.push_back(rd_ev(AUTOINC ? 6'h02 : 6'h01));
        exp_b.push_back(8'hA5);
        exp_b.push_back(AUTOINC ? 8'h5C : 8'hA5);
        i2c_start();
        send_byte(8'h03, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rd_dev_ack got %b want 0", ack);
        else n_pass++;
        send_byte(8'h01, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rd_mem_ack got %b want 0", ack);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            read_byte(i == 0, b);
            want = exp_b.pop_front();
            n_total++;
            if (b !== want) $display("FAIL rd_byte%0d got %h want %h", i, b, want);
            else n_pass++;
        end
        n_total++;
        if ({busy, state} !== {1'b1, ST_WAIT_STOP})
            $display("FAIL rd_nack got busy=%b st=%0d want busy=1 st=%0d",
                     busy, state, ST_WAIT_STOP);
        else n_pass++;
        i2c_stop();
        wq();
        n_total++;
        if (busy !== 1'b0) $display("FAIL rd_busy_stop got %b want 0", busy);
        else n_pass++;
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int k = 0; k < n; k++) begin
            e = '0; o = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL rd_mem%0d got %h want %h", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_wrong_addr();
        logic ack;
        i2c_start();
        send_byte(8'h04, ack);
        n_total++;
        if (ack !== 1'b1) $display("FAIL wa_ack got %b want 1", ack);
        else n_pass++;
        n_total++;
        if ({busy, state} !== {1'b0, ST_WAIT_STOP})
            $display("FAIL wa_state got busy=%b st=%0d want busy=0 st=%0d",
                     busy, state, ST_WAIT_STOP);
        else n_pass++;
        send_byte(8'h55, ack);
        n_total++;
        if (ack !== 1'b1) $display("FAIL wa_ack2 got %b want 1", ack);
        else n_pass++;
        i2c_stop();
        wq();
        n_total++;
        if (state !== ST_IDLE) $display("FAIL wa_idle got %0d want %0d", state, ST_IDLE);
        else n_pass++;
        n_total++;
        if (obs_q.size() != 0) $display("FAIL wa_strobes got %0d want 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_burst_wrap();
        logic [7:0]  tx [4] = '{8'h02, 8'h3F, 8'h11, 8'h22};
        logic        ack;
        logic [16:0] e, o;
        int          n;
        exp_q.push_back(wr_ev(6'h3F, 8'h11));
        exp_q.push_back(wr_ev(AUTOINC ? 6'h00 : 6'h3F, 8'h22));
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(tx[i], ack);
            n_total++;
            if (ack !== 1'b0) $display("FAIL bw_ack%0d got %b want 0", i, ack);
            else n_pass++;
        end
        i2c_stop();
        wq();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int k = 0; k < n; k++) begin
            e = '0; o = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL bw_mem%0d got %h want %h", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_repeated_start();
        logic [7:0]  tx [5] = '{8'h02, 8'h02, 8'h66, 8'h03, 8'h02};
        logic        ack;
        logic [7:0]  b, want;
        logic [16:0] e, o;
        int          n;
        exp_q.push_back(wr_ev(6'h02, 8'h66));
        exp_q.push_back(rd_ev(6'h02));
        exp_b.push_back(8'h66);
        i2c_start();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                i2c_rstart();
                n_total++;
                if (state !== ST_DEV_ADDR)
                    $display("FAIL rs_state got %0d want %0d", state, ST_DEV_ADDR);
                else n_pass++;
            end
            send_byte(tx[i], ack);
            n_total++;
            if (ack !== 1'b0) $display("FAIL rs_ack%0d got %b want 0", i, ack);
            else n_pass++;
        end
        read_byte(1'b0, b);
        want = exp_b.pop_front();
        n_total++;
        if (b !== want) $display("FAIL rs_byte got %h want %h", b, want);
        else n_pass++;
        i2c_stop();
        wq();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int k = 0; k < n; k++) begin
            e = '0; o = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL rs_mem%0d got %h want %h", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0]  tx [5] = '{8'h03, 8'h01, 8'h02, 8'h09, 8'h99};
        logic        ack;
        logic [2:0]  bits;
        logic [16:0] e, o;
        int          n;
        preload(6'h01, 8'hA5);
        exp_q.push_back(rd_ev(6'h01));
        exp_q.push_back(wr_ev(6'h09, 8'h99));
        i2c_start();
        for (int i = 0; i < 2; i++) begin
            send_byte(tx[i], ack);
            n_total++;
            if (ack !== 1'b0) $display("FAIL mr_ack%0d got %b want 0", i, ack);
            else n_pass++;
        end
        for (int i = 2; i >= 0; i--) begin
            scl_m = 1'b0; wq();
            sda_m = 1'b1; wq();
            scl_m = 1'b1; wq();
            bits[i] = sda_line;
            wq();
        end
        n_total++;
        if (bits !== 3'b101) $display("FAIL mr_bits got %b want 101", bits);
        else n_pass++;
        scl_m = 1'b0;
        wq();
        n_total++;
        if ({bus.sda_oe, state} !== {1'b1, ST_RD_DATA})
            $display("FAIL mr_bit4 got oe=%b st=%0d want oe=1 st=%0d",
                     bus.sda_oe, state, ST_RD_DATA);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk8x);
        n_total++;
        if (bus.sda_oe !== 1'b0) $display("FAIL mr_release got %b want 0", bus.sda_oe);
        else n_pass++;
        n_total++;
        if (state !== ST_IDLE) $display("FAIL mr_state got %0d want %0d", state, ST_IDLE);
        else n_pass++;
        reset = 1'b0;
        wq();
        scl_m = 1'b1;
        wq();
        i2c_start();
        for (int i = 2; i < 5; i++) begin
            send_byte(tx[i], ack);
            n_total++;
            if (ack !== 1'b0) $display("FAIL mr_ack%0d got %b want 0", i, ack);
            else n_pass++;
        end
        i2c_stop();
        wq();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int k = 0; k < n; k++) begin
            e = '0; o = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL mr_mem%0d got %h want %h", k, o, e);
            else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_burst_wrap();
        test_repeated_start();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
